qdeact_stream: RTL and testbench
================================

Name: qdeact_stream

Overview:
- Streaming dequantizer: the inverse of the activation quantizer.
- Takes N lanes of unsigned quantized activations (YB bits, YBF fractional bits), subtracts a zero point and multiplies by a signed per-tensor scale.
- Rounds, shifts and saturates each lane to a signed XB-bit fixed-point value with XBF fractional bits.
- Sits between the activation buffer and the next layer's fixed-point datapath; valid/ready on both sides, 3-stage pipeline.

Parameters:
N, 1, lane count
YB, 8, input width (unsigned)
YBF, 4, input fractional bits
SB, 8, scale width (signed)
SBF, 6, scale fractional bits (must be <= SB-2)
XB, 12, output width (signed)
XBF, 8, output fractional bits

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cfg_valid  in  1  load new scale and zero point
cfg_scale  in  SB  signed scale
cfg_zp  in  YB  unsigned zero point
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
s_data  in  N*YB  packed lanes, lane n at [n*YB +: YB]
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  N*XB  packed signed lanes, lane n at [n*XB +: XB]

Behaviour:
- Reset (rstn low, asynchronous): all stage valids 0 (so m_valid=0), m_data=0, scale_r=2**SBF (1.0), zp_r=0.
- Config:
  - cfg_valid high on a clk edge loads scale_r and zp_r.
  - A beat accepted on that same edge uses the old values.
  - Each beat captures scale_r into its S1 register, so a config change never affects beats already in flight.
- S1 (accept stage): per lane, d = signed(YB+1)(y) - signed(YB+1)(zp_r); also stores the scale.
- S2: p = d * scale, signed, YB+1+SB bits, full precision, no truncation.
- S3: sh = YBF+SBF-XBF.
  - If sh > 0: r = (p + 2**(sh-1)) >>> sh (arithmetic shift; round half toward +inf).
  - If sh <= 0: r = p <<< -sh.
  - Compute in YB+SB+2+max(0,-sh) bits so nothing overflows.
  - Saturate r to [-2**(XB-1), 2**(XB-1)-1].
- Handshake:
  - Each stage k has valid v_k and advances when !v_k | ready_k, where ready_3 = m_ready and ready_k = !v_{k+1} | ready_{k+1}.
  - s_ready = !v_1 | ready_1 (combinational from m_ready; no register needed).
  - Latency: 3 cycles from acceptance to m_valid with no stall.
  - Throughput: 1 beat/cycle.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Output rules:
  - m_data holds stable while m_valid & !m_ready.
  - m_valid never drops without a handshake.
  - Beat order is preserved.
  - At most 3 beats in flight; when all three are held and m_ready is low, s_ready=0.
- Simultaneous s_valid accept and m_ready pop with a full pipeline: the whole pipeline shifts, s_ready stays 1.
- Reset mid-stream: in-flight beats are discarded and config returns to defaults; first beat after rstn release emerges 3 cycles after acceptance.
- Lanes are independent and share one valid.

Optional Feature:
- Macro QDEACT_SAT_FLAG_EN.
- Defined, adds:
  - output m_sat [N-1:0]: per-lane flag, high when that lane was clipped; aligned with m_data, same stall rules, reset 0.
  - output sat_seen [0:0]: sticky OR of every handshaked m_sat bit; cleared by cfg_valid or reset; if clear and set coincide, set wins.
- Undefined: both ports absent; saturation arithmetic unchanged.

Test Plan:
- Defaults (sh=2), cfg scale=64, zp=0; s_data=32 -> m_data=512 (2.0 in Q8) exactly 3 cycles after accept.
- Rounding: zp=16, y=0, scale=64 -> -256; zp=0, y=1, scale=2 -> 1 (half rounds up); y=1, scale=1 -> 0.
- Saturation: y=255, zp=0, scale=127 -> 2047; y=0, zp=255, scale=127 -> -2048. With QDEACT_SAT_FLAG_EN, m_sat=1 on both and sat_seen=1 until next cfg_valid.
- Backpressure: stream y=0..19 continuously, m_ready low cycles 5-9. Check:
  - s_ready drops only once 3 beats are held.
  - m_data stable while stalled.
  - All 20 outputs arrive in order, no loss or duplication.
- Config mid-stream: beats A,B accepted at scale=64, cfg_valid with scale=32 on B's accept edge, beat C after. A and B use 64; C uses 32.
- Reset: assert rstn for 1 cycle with 3 beats in flight. m_valid=0 immediately; no stale beat appears afterwards; scale returns to 64, zp to 0.

Source files
------------

// File: rtl/qdeact_stream.sv
// qdeact_stream: N-lane streaming dequantizer (zero-point subtract, signed scale, round/shift/saturate), 3-stage valid/ready pipeline.
// Optional macro QDEACT_SAT_FLAG_EN adds per-lane m_sat and a sticky sat_seen output.
module qdeact_stream #(
  parameter int N   = 1,
  parameter int YB  = 8,
  parameter int YBF = 4,
  parameter int SB  = 8,
  parameter int SBF = 6,
  parameter int XB  = 12,
  parameter int XBF = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  input  logic [SB-1:0]    cfg_scale,
  input  logic [YB-1:0]    cfg_zp,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N*YB-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N*XB-1:0]  m_data
`ifdef QDEACT_SAT_FLAG_EN
  ,
  output logic [N-1:0]     m_sat,
  output logic [0:0]       sat_seen
`endif
);

  localparam int DW  = YB + 1;
  localparam int PW  = YB + 1 + SB;
  localparam int SH  = YBF + SBF - XBF;
  localparam int SHR = (SH > 0) ? SH : 0;
  localparam int SHL = (SH < 0) ? -SH : 0;
  localparam int RW  = YB + SB + 2 + SHL;
  localparam int RSH = (SH > 0) ? SH - 1 : 0;

  localparam logic signed [RW-1:0] RND  = (SH > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RSH) : '0;
  localparam logic signed [RW-1:0] XMAX = {{(RW-XB+1){1'b0}}, {(XB-1){1'b1}}};
  localparam logic signed [RW-1:0] XMIN = {{(RW-XB+1){1'b1}}, {(XB-1){1'b0}}};
  localparam logic [SB-1:0]        SCALE_ONE = {{(SB-1){1'b0}}, 1'b1} << SBF;

  logic [SB-1:0]        scale_q, scale_d;
  logic [YB-1:0]        zp_q, zp_d;
  logic                 v1_q, v1_d;
  logic                 v2_q, v2_d;
  logic                 v3_q, v3_d;
  logic signed [DW-1:0] d1_q [N];
  logic signed [DW-1:0] d1_d [N];
  logic signed [SB-1:0] sc1_q, sc1_d;
  logic signed [PW-1:0] p2_q [N];
  logic signed [PW-1:0] p2_d [N];
  logic [N*XB-1:0]      x3_q, x3_d;
  logic                 adv1, adv2, adv3;
  logic signed [RW-1:0] pe, r;
  logic                 hi, lo;
`ifdef QDEACT_SAT_FLAG_EN
  logic [N-1:0]         sat3_q, sat3_d;
  logic                 sat_seen_q, sat_seen_d;
`endif

  // Each stage advances when empty or when the next one moves, so bubbles collapse.
  always_comb begin
    adv3    = !v3_q || m_ready;
    adv2    = !v2_q || adv3;
    adv1    = !v1_q || adv2;
    s_ready = adv1;
  end

  always_comb begin
    scale_d = scale_q;
    zp_d    = zp_q;
    if (cfg_valid) begin
      scale_d = cfg_scale;
      zp_d    = cfg_zp;
    end
    v1_d  = adv1 ? s_valid : v1_q;
    v2_d  = adv2 ? v1_q : v2_q;
    v3_d  = adv3 ? v2_q : v3_q;
    sc1_d = sc1_q;
    if (adv1 && s_valid) sc1_d = scale_q;
    for (int unsigned n = 0; n < N; n++) begin
      d1_d[n] = d1_q[n];
      p2_d[n] = p2_q[n];
      if (adv1 && s_valid)
        d1_d[n] = $signed({1'b0, s_data[n*YB +: YB]}) - $signed({1'b0, zp_q});
      if (adv2 && v1_q)
        p2_d[n] = PW'(d1_q[n]) * PW'(sc1_q);
    end
  end

  // Right shift with rounding and left shift are folded into one expression:
  // for a given SH, one of SHR/SHL is zero and RND is zero whenever SHR is.
  always_comb begin
    x3_d = x3_q;
    pe   = '0;
    r    = '0;
    hi   = 1'b0;
    lo   = 1'b0;
`ifdef QDEACT_SAT_FLAG_EN
    sat3_d = sat3_q;
`endif
    for (int unsigned n = 0; n < N; n++) begin
      pe = RW'(p2_q[n]) + RND;
      r  = (pe >>> SHR) <<< SHL;
      hi = (r > XMAX);
      lo = (r < XMIN);
      if (adv3 && v2_q) begin
        x3_d[n*XB +: XB] = hi ? XMAX[XB-1:0] : (lo ? XMIN[XB-1:0] : r[XB-1:0]);
`ifdef QDEACT_SAT_FLAG_EN
        sat3_d[n] = hi || lo;
`endif
      end
    end
  end

`ifdef QDEACT_SAT_FLAG_EN
  always_comb begin
    sat_seen_d = sat_seen_q;
    if (cfg_valid) sat_seen_d = 1'b0;
    if (v3_q && m_ready && (|sat3_q)) sat_seen_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scale_q <= SCALE_ONE;
      zp_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sc1_q   <= '0;
      x3_q    <= '0;
      for (int unsigned n = 0; n < N; n++) begin
        d1_q[n] <= '0;
        p2_q[n] <= '0;
      end
`ifdef QDEACT_SAT_FLAG_EN
      sat3_q     <= '0;
      sat_seen_q <= 1'b0;
`endif
    end else begin
      scale_q <= scale_d;
      zp_q    <= zp_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      sc1_q   <= sc1_d;
      x3_q    <= x3_d;
      for (int unsigned n = 0; n < N; n++) begin
        d1_q[n] <= d1_d[n];
        p2_q[n] <= p2_d[n];
      end
`ifdef QDEACT_SAT_FLAG_EN
      sat3_q     <= sat3_d;
      sat_seen_q <= sat_seen_d;
`endif
    end
  end

  assign m_valid = v3_q;
  assign m_data  = x3_q;
`ifdef QDEACT_SAT_FLAG_EN
  assign m_sat    = sat3_q;
  assign sat_seen = sat_seen_q;
`endif

endmodule

// File: tb/tb_qdeact_stream.sv
// tb_qdeact_stream: directed and randomized checks of qdeact_stream against a queue-based arithmetic reference model.
module tb_qdeact_stream;
  localparam int N = 1, YB = 8, YBF = 4, SB = 8, SBF = 6, XB = 12, XBF = 8;
  localparam int SH   = YBF + SBF - XBF;
  localparam int XMAX = 2**(XB-1) - 1;
  localparam int XMIN = -(2**(XB-1));

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic signed [SB-1:0] cfg_scale = '0;
  logic [YB-1:0]        cfg_zp = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [N*YB-1:0]      s_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [N*XB-1:0]      m_data;
`ifdef QDEACT_SAT_FLAG_EN
  logic [N-1:0]         m_sat;
  logic [0:0]           sat_seen;
`endif

  qdeact_stream #(.N(N), .YB(YB), .YBF(YBF), .SB(SB), .SBF(SBF), .XB(XB), .XBF(XBF)) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_scale(cfg_scale), .cfg_zp(cfg_zp),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef QDEACT_SAT_FLAG_EN
    , .m_sat(m_sat), .sat_seen(sat_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int data; bit sat; int acyc; } beat_t;
  beat_t q[$];
  int  ntests = 0, nfail = 0, cyc = 0;
  int  mscale = 64, mzp = 0;
  bit  msat_seen = 0, prev_stall = 0, last_acc = 0, chk_lat = 0;
  bit  use_dir = 0, dir_sat = 0;
  int  dir_exp = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int fdiv(int a, int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic model(input int y, output int res, output bit sat);
    int p;
    p = (y - mzp) * mscale;
    if (SH > 0) res = fdiv(p + 2**(SH-1), 2**SH);
    else        res = p * (2**(-SH));
    sat = (res > XMAX) || (res < XMIN);
    if (res > XMAX) res = XMAX;
    if (res < XMIN) res = XMIN;
  endtask

  task automatic cycle();
    bit acc, pop, psat, stall_now;
    beat_t b;
    @(negedge clk);
    check("s_ready", 32'(s_ready), 32'((q.size() < 3) || (m_ready === 1'b1)));
    if (prev_stall) check("hold_valid", 32'(m_valid), 1);
    if (q.size() == 0) check("idle_valid", 32'(m_valid), 0);
    else if (m_valid === 1'b1) begin
      check("data", 32'($signed(m_data)), q[0].data);
`ifdef QDEACT_SAT_FLAG_EN
      check("m_sat", 32'(m_sat), 32'(q[0].sat));
`endif
    end
`ifdef QDEACT_SAT_FLAG_EN
    check("sat_seen", 32'(sat_seen), 32'(msat_seen));
`endif
    acc       = (s_valid === 1'b1) && (s_ready === 1'b1);
    pop       = (m_valid === 1'b1) && (m_ready === 1'b1) && (q.size() > 0);
    stall_now = (m_valid === 1'b1) && (m_ready === 1'b0);
    psat      = 1'b0;
    if (pop) begin
      if (chk_lat) check("latency", cyc - q[0].acyc, 3);
      psat = q[0].sat;
      q.delete(0);
    end
    if (acc) begin
      if (use_dir) begin
        b.data = dir_exp;
        b.sat  = dir_sat;
      end else model(int'(s_data), b.data, b.sat);
      b.acyc = cyc;
      q.push_back(b);
    end
    last_acc = acc;
    @(posedge clk);
    if (psat) msat_seen = 1'b1;
    else if (cfg_valid) msat_seen = 1'b0;
    if (cfg_valid) begin
      mscale = int'(cfg_scale);
      mzp    = int'(cfg_zp);
    end
    prev_stall = stall_now;
    cyc++;
    #1;
  endtask

  task automatic do_cfg(int sc, int zp);
    cfg_valid = 1'b1;
    cfg_scale = SB'(sc);
    cfg_zp    = YB'(zp);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic send(int y, int e, bit s);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = YB'(y);
    use_dir = 1'b1;
    dir_exp = e;
    dir_sat = s;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      done = last_acc;
    end
    check("send_acc", 32'(done), 1);
    s_valid = 1'b0;
    use_dir = 1'b0;
  endtask

  task automatic drain();
    s_valid   = 1'b0;
    cfg_valid = 1'b0;
    m_ready   = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
    check("drain_empty", q.size(), 0);
    cycle();
  endtask

  initial begin
    int i;
    repeat (2) cycle();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    rstn    = 1'b1;
    m_ready = 1'b1;
    chk_lat = 1'b1;

    // defaults and basic conversion
    send(32, 512, 0);
    do_cfg(64, 0);
    send(32, 512, 0);
    drain();

    // rounding
    do_cfg(64, 16);
    send(0, -256, 0);
    do_cfg(2, 0);
    send(1, 1, 0);
    do_cfg(1, 0);
    send(1, 0, 0);
    drain();

    // saturation both ways, sat_seen sticky until next config
    do_cfg(127, 0);
    send(255, 2047, 1);
    do_cfg(127, 255);
    send(0, -2048, 1);
    drain();
    repeat (3) cycle();
    do_cfg(64, 0);
    repeat (2) cycle();

    // config change on B's accept edge
    s_valid = 1'b1; s_data = YB'(32); use_dir = 1'b1; dir_exp = 512; dir_sat = 1'b0;
    cycle();
    check("cfgA_acc", 32'(last_acc), 1);
    cfg_valid = 1'b1; cfg_scale = SB'(32);
    cycle();
    check("cfgB_acc", 32'(last_acc), 1);
    cfg_valid = 1'b0; dir_exp = 256;
    cycle();
    check("cfgC_acc", 32'(last_acc), 1);
    s_valid = 1'b0; use_dir = 1'b0;
    drain();

    // backpressure: 20 beats, m_ready low on cycles 5-9
    chk_lat = 1'b0;
    do_cfg(64, 0);
    i = 0;
    for (int c = 0; c < 60 && i < 20; c++) begin
      s_valid = 1'b1;
      s_data  = YB'(i);
      m_ready = !(c >= 5 && c <= 9);
      use_dir = 1'b1;
      dir_exp = 16 * i;
      dir_sat = 1'b0;
      cycle();
      if (last_acc) i++;
    end
    check("bp_count", i, 20);
    use_dir = 1'b0;
    drain();

    // randomized traffic with random config changes and backpressure
    for (int c = 0; c < 400; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = YB'($urandom);
      m_ready   = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_scale = SB'($urandom);
      cfg_zp    = ($urandom_range(0, 1) != 0) ? YB'($urandom_range(0, 40)) : YB'($urandom);
      cycle();
    end
    drain();
    chk_lat = 1'b1;

    // reset with three beats in flight
    do_cfg(64, 16);
    s_valid = 1'b1;
    s_data  = YB'(32);
    repeat (3) cycle();
    s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 0);
    check("arst_data", 32'(m_data), 0);
    q.delete();
    mscale = 64; mzp = 0; msat_seen = 1'b0; prev_stall = 1'b0;
    cycle();
    rstn = 1'b1;
    send(32, 512, 0);
    drain();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
